// File: rtl/ser2par_pkg.sv
// rtl/ser2par_pkg.sv - shared width helpers and the even-parity function for ser2par_buffer
package ser2par_pkg;

  localparam int PARITY_MAX_W = 64;

  function automatic int frame_width(input int data_w, input bit par_en);
    return par_en ? data_w + 1 : data_w;
  endfunction

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Zero-extended words are fine here because the extra zeros do not change the XOR.
  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ser2par_fifo.sv
// rtl/ser2par_fifo.sv - first-word-fall-through FIFO with wrap-bit full/empty detection
module ser2par_fifo
  import ser2par_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int LVL_W  = level_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic [LVL_W-1:0]  level,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a word when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = push_data;
      wr_ptr_d                = wr_ptr_q + PTR_ONE;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  assign head_data = mem_q[rd_ptr_q[AW-1:0]];
  assign level     = LVL_W'(wr_ptr_q - rd_ptr_q);

endmodule

// File: rtl/ser2par_buffer.sv
// rtl/ser2par_buffer.sv - serial-to-parallel deserializer feeding an output FIFO
// Optional even-parity frame check is built when SER2PAR_PARITY_EN is defined.
module ser2par_buffer
  import ser2par_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enable,
  input  logic                         data_in,
  input  logic                         out_ready,
  input  logic                         clr_err,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_valid,
  output logic                         word_done,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                         overrun,
  output logic                         par_err
);

`ifdef SER2PAR_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  localparam int FRAME_W = frame_width(DATA_W, PAR_EN);
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] word;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              word_done_q, word_done_d;
  logic              overrun_q, overrun_d;
  logic              frame_end;
  logic              frame_ok;
  logic              data_edge;
  logic              push;
  logic              drop;
  logic              fifo_full;
  logic              fifo_empty;

  assign shifted   = MSB_FIRST ? {shreg_q[DATA_W-2:0], data_in} : {data_in, shreg_q[DATA_W-1:1]};
  assign frame_end = enable && (cnt_q == CNT_LAST);

`ifdef SER2PAR_PARITY_EN
  logic par_err_q, par_err_d;

  // The parity bit is checked but never enters the shift register.
  assign data_edge = enable && (cnt_q != CNT_LAST);
  assign word      = shreg_q;
  assign frame_ok  = (even_parity(PARITY_MAX_W'(shreg_q)) == data_in);

  always_comb begin
    par_err_d = par_err_q;
    if (frame_end && !frame_ok) begin
      par_err_d = 1'b1;
    end else if (clr_err) begin
      par_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= par_err_d;
    end
  end

  assign par_err = par_err_q;
`else
  assign data_edge = enable;
  assign word      = shifted;
  assign frame_ok  = 1'b1;
  assign par_err   = 1'b0;
`endif

  assign push = frame_end && frame_ok;
  assign drop = push && fifo_full && !out_ready;

  always_comb begin
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    word_done_d = frame_end;
    overrun_d   = overrun_q;
    if (data_edge) begin
      shreg_d = shifted;
    end
    if (!enable || frame_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
    // A new drop outranks a simultaneous clear.
    if (drop) begin
      overrun_d = 1'b1;
    end else if (clr_err) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg_q     <= '0;
      cnt_q       <= '0;
      word_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      word_done_q <= word_done_d;
      overrun_q   <= overrun_d;
    end
  end

  ser2par_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .push      (push),
    .push_data (word),
    .pop       (out_ready),
    .head_data (out_data),
    .level     (level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign word_done = word_done_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_ser2par_buffer.sv
// tb/tb_ser2par_buffer.sv - scoreboard bench for ser2par_buffer (MSB-first and LSB-first instances)
module tb_ser2par_buffer;

`ifdef SER2PAR_PARITY_EN
  localparam int FW = 9;
`else
  localparam int FW = 8;
`endif

  logic       clk;
  logic       rst_n;
  logic       rst1_n;
  logic       enable;
  logic       data_in;
  logic       out_ready;
  logic       clr_err;
  logic [7:0] out_data,  out_data1;
  logic       out_valid, out_valid1;
  logic       word_done, word_done1;
  logic [2:0] level,     level1;
  logic       overrun,   overrun1;
  logic       par_err,   par_err1;

  int checks = 0;
  int errors = 0;
  logic [7:0] q0[$];
  logic [7:0] q1[$];

  ser2par_buffer #(.DATA_W(8), .DEPTH(4), .MSB_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst_n), .enable(enable), .data_in(data_in),
    .out_ready(out_ready), .clr_err(clr_err), .out_data(out_data),
    .out_valid(out_valid), .word_done(word_done), .level(level),
    .overrun(overrun), .par_err(par_err)
  );

  ser2par_buffer #(.DATA_W(8), .DEPTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst1_n), .enable(enable), .data_in(data_in),
    .out_ready(out_ready), .clr_err(clr_err), .out_data(out_data1),
    .out_valid(out_valid1), .word_done(word_done1), .level(level1),
    .overrun(overrun1), .par_err(par_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head word is compared against the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_msb unexpected actual=%0h required=none", out_data);
      end else begin
        chk("pop_msb", out_data, q0.pop_front());
      end
    end
    if (rst1_n && out_valid1 && out_ready) begin
      if (q1.size() == 0) begin
        checks++; errors++;
        $display("FAIL pop_lsb unexpected actual=%0h required=none", out_data1);
      end else begin
        chk("pop_lsb", out_data1, q1.pop_front());
      end
    end
  end

  function automatic logic [8:0] frame(input logic [7:0] w, input bit bad);
    logic [8:0] f;
    for (int i = 0; i < 8; i++) f[i] = w[7-i];
    f[8] = (^w) ^ bad;
    return f;
  endfunction

  task automatic send_bit(input logic b);
    enable  = 1'b1;
    data_in = b;
    @(posedge clk); #1;
  endtask

  task automatic send_word(input logic [7:0] w, input bit bad, input bit rdy_last, input bit clr_last);
    logic [8:0] f;
    f = frame(w, bad);
    for (int i = 0; i < FW; i++) begin
      out_ready = (i == FW - 1) ? rdy_last : 1'b0;
      clr_err   = (i == FW - 1) ? clr_last : 1'b0;
      send_bit(f[i]);
    end
    out_ready = 1'b0;
    clr_err   = 1'b0;
  endtask

  task automatic idle(input int n);
    enable = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic drain(input int n);
    out_ready = 1'b1;
    idle(n);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [8:0] f1, f2;
    rst_n = 1'b0; rst1_n = 1'b0; enable = 1'b0; data_in = 1'b0;
    out_ready = 1'b0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_level", level, 0);
    chk("rst_data", out_data, 0);
    chk("rst_done", word_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_par_err", par_err, 0);
    rst_n = 1'b1; rst1_n = 1'b1;
    idle(1);

    // Bit order: 1,0,1,1,0,1,0,0
    f1 = frame(8'hB4, 1'b0);
    for (int i = 0; i < FW; i++) begin
      send_bit(f1[i]);
      if (i == FW - 2) chk("valid_early", out_valid, 0);
    end
    chk("order_valid", out_valid, 1);
    chk("order_done", word_done, 1);
    chk("order_level", level, 1);
    chk("order_msb", out_data, 8'hB4);
    chk("order_lsb", out_data1, 8'h2D);
    chk("order_lsb_level", level1, 1);
    idle(1);
    chk("done_one_cycle", word_done, 0);
    q0.push_back(8'hB4); q1.push_back(8'h2D);
    drain(1);
    chk("order_drained", level, 0);
    chk("order_drained_lsb", level1, 0);
    rst1_n = 1'b0;

    // Back-to-back frames
    f1 = frame(8'hB4, 1'b0);
    f2 = frame(8'h3C, 1'b0);
    q0.push_back(8'hB4); q0.push_back(8'h3C);
    for (int i = 0; i < 2 * FW; i++) begin
      send_bit((i < FW) ? f1[i] : f2[i-FW]);
      chk("b2b_done", word_done, (i == FW - 1) || (i == 2 * FW - 1));
    end
    chk("b2b_level", level, 2);
    drain(3);
    chk("b2b_drained", level, 0);

    // Overrun: 0x05 is dropped
    for (int w = 1; w <= 5; w++) begin
      if (w <= 4) q0.push_back(8'(w));
      send_word(8'(w), 1'b0, 1'b0, 1'b0);
    end
    chk("ovr_level", level, 4);
    chk("ovr_flag", overrun, 1);
    chk("ovr_head", out_data, 8'h01);
    // Full with simultaneous pop accepts 0x06
    q0.push_back(8'h06);
    send_word(8'h06, 1'b0, 1'b1, 1'b0);
    chk("full_pushpop_level", level, 4);
    chk("full_pushpop_head", out_data, 8'h02);
    // Clear coinciding with a new drop: set wins
    send_word(8'h07, 1'b0, 1'b0, 1'b1);
    chk("clr_vs_set", overrun, 1);
    idle(1);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk("clr_overrun", overrun, 0);
    drain(5);
    chk("ovr_drained", level, 0);

    // Abort after 5 bits
    repeat (5) send_bit(1'b1);
    idle(1);
    q0.push_back(8'h5A);
    send_word(8'h5A, 1'b0, 1'b0, 1'b0);
    chk("abort_level", level, 1);
    chk("abort_head", out_data, 8'h5A);
    drain(2);

    // Reset mid-frame with two words queued
    send_word(8'h11, 1'b0, 1'b0, 1'b0);
    send_word(8'h22, 1'b0, 1'b0, 1'b0);
    repeat (3) send_bit(1'b1);
    chk("pre_rst_level", level, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_level", level, 0);
    chk("async_rst_data", out_data, 0);
    chk("async_rst_done", word_done, 0);
    enable = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q0.push_back(8'hC3);
    send_word(8'hC3, 1'b0, 1'b0, 1'b0);
    chk("post_rst_level", level, 1);
    drain(2);

`ifdef SER2PAR_PARITY_EN
    q0.push_back(8'hB4);
    send_word(8'hB4, 1'b0, 1'b0, 1'b0);
    chk("par_good_level", level, 1);
    chk("par_good_flag", par_err, 0);
    send_word(8'hB4, 1'b1, 1'b0, 1'b0);
    chk("par_bad_flag", par_err, 1);
    chk("par_bad_done", word_done, 1);
    chk("par_bad_level", level, 1);
    chk("par_bad_overrun", overrun, 0);
    drain(2);
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk("par_clr", par_err, 0);
`else
    chk("par_tied_low", par_err, 0);
`endif

    idle(2);
    chk("sb_empty", q0.size(), 0);
    chk("final_level", level, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
